uram_read_streamer: RTL and testbench

URAM_READ_STREAMER -- requirements
Module: uram_read_streamer

---
 rtl/uram_read_streamer.sv | 136 +++++++++++++
 tb/tb_uram_read_streamer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uram_read_streamer.sv
// uram_read_streamer: issues a burst of sequential reads to a 1-cycle-latency
// memory port and streams the returned words out through a 2-entry FIFO.
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. out_valid depends only on FIFO occupancy (never on
// out_ready), and out_data/out_last stay stable while out_valid=1 and
// out_ready=0.
module uram_read_streamer #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0]    dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_next_addr;
  logic [ADDRESS_WIDTH-1:0] r_last_addr;
  logic [ADDRESS_WIDTH:0]   r_remaining;
  logic                     r_inflight;
  logic                     r_inflight_last;
  logic                     r_done;
  logic [DATA_WIDTH-1:0]    r_fifo_data [2];
  logic [1:0]               r_fifo_last;
  logic                     r_rd_ptr;
  logic                     r_wr_ptr;
  logic [1:0]               r_count;

  logic w_handshake;
  logic w_issue;
  logic w_issue_last;
  logic w_start_burst;
  logic w_start_empty;
  logic w_has_room;

  assign out_valid     = (r_count != 2'd0);
  assign w_handshake   = out_valid & out_ready;
  assign w_start_burst = (r_state == S_IDLE) && start && (length != '0);
  assign w_start_empty = (r_state == S_IDLE) && start && (length == '0);
  // Buffered plus outstanding words must stay within the 2 FIFO slots; a pop
  // in the same cycle frees one slot for the read returning next cycle.
  assign w_has_room    = (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2);
  assign w_issue       = (r_state == S_ISSUE) && (w_has_room || w_handshake);
  assign w_issue_last  = w_issue && (r_remaining == (ADDRESS_WIDTH+1)'(1));

  // While not issuing, raddr holds the most recently issued address.
  assign raddr     = w_issue ? r_next_addr : r_last_addr;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign out_data  = r_fifo_data[r_rd_ptr];
  assign out_last  = out_valid & r_fifo_last[r_rd_ptr];
  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> ISSUE on a non-empty start, ISSUE -> DRAIN after
  // the last read, DRAIN -> IDLE on the final word's handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_burst) w_next_state = S_ISSUE;
      S_ISSUE: if (w_issue_last) w_next_state = S_DRAIN;
      S_DRAIN: if (w_handshake && out_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Read issue bookkeeping: address counter, words left, in-flight tag, done.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_next_addr     <= '0;
      r_last_addr     <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      if (w_start_burst) begin
        r_next_addr <= base_addr;
        r_remaining <= length;
      end else if (w_issue) begin
        r_last_addr <= r_next_addr;
        r_next_addr <= r_next_addr + ADDRESS_WIDTH'(1);
        r_remaining <= r_remaining - (ADDRESS_WIDTH+1)'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
      r_done          <= w_start_empty ||
                         ((r_state == S_DRAIN) && w_handshake && out_last);
    end
  end

  // 2-entry FIFO: capture memory data the cycle after each issued read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= 2'b00;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= dout;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_handshake) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_handshake};
    end
  end

endmodule

// File: tb/tb_uram_read_streamer.sv
// Testbench for uram_read_streamer: memory model mem[a]=a*3 with 1-cycle
// latency, reference word list built per burst, handshake monitor comparing
// against an expected queue.
module tb_uram_read_streamer;

  localparam int DW = 64;
  localparam int AW = 12;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr;
  logic [DW-1:0] dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_expected = 0;
  int hs_count = 0;
  int ready_mode = 0;
  int ready_cyc = 0;

  logic [DW:0]   exp_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  uram_read_streamer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // Clock and reset-independent memory model.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) dout <= DW'(raddr) * DW'(3);

  task automatic check(input string name, input logic [DW-1:0] actual,
                       input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Consumer backpressure: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((ready_cyc % 4) == 0) || ((ready_cyc % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    ready_cyc++;
  end

  // Monitor: compare each accepted word, check stall stability, count done.
  always @(negedge clock) begin
    logic [DW:0] e;
    if (reset_n) begin
      if (prev_stall) begin
        check("stall_valid", DW'(out_valid), DW'(1));
        check("stall_data", out_data, prev_data);
        check("stall_last", DW'(out_last), DW'(prev_last));
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_data, '1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[DW-1:0]);
          check("out_last", DW'(out_last), DW'(e[DW]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) done_seen++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Reference: a burst yields words ((base+i) mod 2^AW)*3, last flag on the final one.
  task automatic issue_start(input int base, input int len);
    logic [DW-1:0] w;
    start     = 1'b1;
    base_addr = AW'(base);
    length    = (AW+1)'(len);
    for (int i = 0; i < len; i++) begin
      w = DW'((base + i) % (1 << AW)) * DW'(3);
      exp_q.push_back({(i == len - 1), w});
    end
    done_expected++;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_seen >= done_expected) break;
      tick();
    end
    check("done_timeout", DW'(done_seen >= done_expected), DW'(1));
    repeat (3) tick();
    check("done_count", DW'(done_seen), DW'(done_expected));
    check("queue_empty", DW'(exp_q.size()), DW'(0));
    check("idle_busy", DW'(busy), DW'(0));
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clock);
    check({tag, "_busy"}, DW'(busy), DW'(0));
    check({tag, "_done"}, DW'(done), DW'(0));
    check({tag, "_out_valid"}, DW'(out_valid), DW'(0));
    check({tag, "_out_last"}, DW'(out_last), DW'(0));
    check({tag, "_raddr"}, DW'(raddr), DW'(0));
    check({tag, "_out_data"}, out_data, DW'(0));
  endtask

  initial begin
    int target;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    check_reset_values("reset");
    tick();

    // Basic burst: 4 words, back-to-back, last on 0x39, done one cycle later.
    ready_mode = 0;
    tick();
    issue_start(32'h010, 4);
    @(negedge clock);
    check("lat_valid_c0", DW'(out_valid), DW'(0));
    tick();
    @(negedge clock);
    check("lat_valid_c1", DW'(out_valid), DW'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clock);
      check("burst_valid", DW'(out_valid), DW'(1));
      check("burst_data", out_data, DW'(32'h30 + 3 * k));
      check("burst_last", DW'(out_last), DW'(k == 3));
    end
    tick();
    @(negedge clock);
    check("burst_done", DW'(done), DW'(1));
    check("burst_valid_after", DW'(out_valid), DW'(0));
    wait_done(50);

    // Address wrap: 0xFFE, 0xFFF, 0x000, 0x001, then raddr holds.
    issue_start(32'hFFE, 4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("wrap_raddr", DW'(raddr), DW'((32'hFFE + (k < 4 ? k : 3)) % 4096));
      tick();
    end
    wait_done(50);

    // Zero-length request: done next cycle, never busy, no words.
    issue_start(0, 0);
    @(negedge clock);
    check("zero_done", DW'(done), DW'(1));
    check("zero_busy", DW'(busy), DW'(0));
    check("zero_valid", DW'(out_valid), DW'(0));
    tick();
    @(negedge clock);
    check("zero_done_clear", DW'(done), DW'(0));
    check("zero_busy2", DW'(busy), DW'(0));
    wait_done(10);

    // Backpressure pattern 1,0,0,1 over an 8-word burst.
    ready_mode = 1;
    issue_start(int'($urandom_range(0, 4095)), 8);
    wait_done(200);

    // Reset mid-burst after 3 of 6 words accepted.
    ready_mode = 0;
    target = hs_count + 3;
    issue_start(32'h200, 6);
    for (int i = 0; i < 50; i++) begin
      if (hs_count >= target) break;
      tick();
    end
    check("reset_mid_reached", DW'(hs_count >= target), DW'(1));
    reset_n = 1'b0;
    exp_q.delete();
    done_expected = done_seen;
    tick();
    reset_n = 1'b1;
    check_reset_values("midreset");
    tick();
    issue_start(32'h100, 2);
    wait_done(50);

    // Start while busy is ignored.
    ready_mode = 2;
    issue_start(32'h050, 6);
    repeat (2) tick();
    start     = 1'b1;
    base_addr = AW'(32'h700);
    length    = (AW+1)'(5);
    tick();
    start = 1'b0;
    wait_done(200);

    // Full address space in one burst.
    ready_mode = 0;
    issue_start(int'($urandom_range(0, 4095)), 4096);
    wait_done(5000);

    // Random bursts with random backpressure.
    for (int n = 0; n < 25; n++) begin
      ready_mode = int'($urandom_range(0, 2));
      issue_start(int'($urandom_range(0, 4095)), int'($urandom_range(0, 20)));
      wait_done(300);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
